// File: rtl/rs_slot_allocator.sv
// Reservation-station occupancy tracker: grants the highest-index free slot each cycle, frees issued entries, clears on flush.
// Grant is combinational from registered occupancy; state and status outputs update one cycle after fire/free/flush.
module rs_slot_allocator #(
  parameter int DEPTH = 8,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [IW-1:0]    alloc_idx,
  input  logic [DEPTH-1:0] free_mask,
  input  logic             flush,
  output logic [DEPTH-1:0] occupied,
  output logic [CW-1:0]    free_count,
  output logic             full,
  output logic             empty,
  output logic             err_double_free
);

  logic [DEPTH-1:0] occ_q, occ_d;
  logic [CW-1:0]    free_cnt_q, free_cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             err_q, err_d;
  logic [DEPTH-1:0] grant_onehot;
  logic [CW-1:0]    pop;
  logic             fire;

  // Ascending scan so the last free entry seen (the highest) wins; 0 when full.
  always_comb begin
    alloc_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!occ_q[i]) alloc_idx = i[IW-1:0];
    end
  end

  assign alloc_ready = !full_q && !flush;
  assign fire        = alloc_req && alloc_ready;

  always_comb begin
    grant_onehot            = '0;
    grant_onehot[alloc_idx] = fire;
  end

  // Freeing an unoccupied entry is flagged but otherwise harmless; flush suppresses the flag.
  always_comb begin
    if (flush) begin
      occ_d = '0;
      err_d = 1'b0;
    end else begin
      occ_d = (occ_q & ~free_mask) | grant_onehot;
      err_d = |(free_mask & ~occ_q);
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pop = pop + CW'(occ_d[i]);
    end
    free_cnt_d = CW'(DEPTH) - pop;
    full_d     = &occ_d;
    empty_d    = ~|occ_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q      <= '0;
      free_cnt_q <= CW'(DEPTH);
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      free_cnt_q <= free_cnt_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      err_q      <= err_d;
    end
  end

  assign occupied        = occ_q;
  assign free_count      = free_cnt_q;
  assign full            = full_q;
  assign empty           = empty_q;
  assign err_double_free = err_q;

endmodule

// File: tb/tb_rs_slot_allocator.sv
// Bench for rs_slot_allocator (DEPTH=8): behavioural model checked every negedge plus directed literal checks.
module tb_rs_slot_allocator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_req = 1'b0;
  logic       alloc_ready;
  logic [2:0] alloc_idx;
  logic [7:0] free_mask = 8'h00;
  logic       flush = 1'b0;
  logic [7:0] occupied;
  logic [3:0] free_count;
  logic       full, empty, err_double_free;

  int checks = 0;
  int failures = 0;

  rs_slot_allocator #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_idx(alloc_idx), .free_mask(free_mask), .flush(flush), .occupied(occupied),
    .free_count(free_count), .full(full), .empty(empty), .err_double_free(err_double_free)
  );

  always #5 clk = ~clk;

  // Model: a set of busy slots; the grant is the largest slot number not in the set.
  bit [7:0] m_occ = 8'h00;
  bit       m_err = 1'b0;

  function automatic int highest_free(input bit [7:0] occ);
    for (int i = 7; i >= 0; i--) if (!occ[i]) return i;
    return 0;
  endfunction

  function automatic int n_busy(input bit [7:0] occ);
    int n = 0;
    for (int i = 0; i < 8; i++) n += occ[i];
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_occ = 8'h00;
      m_err = 1'b0;
    end else if (flush) begin
      m_occ = 8'h00;
      m_err = 1'b0;
    end else begin
      bit granted;
      int g;
      granted = alloc_req && (m_occ != 8'hFF);
      g = highest_free(m_occ);
      m_err = (free_mask & ~m_occ) != 8'h00;
      m_occ = m_occ & ~free_mask;
      if (granted) m_occ[g] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_occupied", occupied, m_occ);
      chk("m_free_count", free_count, 8 - n_busy(m_occ));
      chk("m_full", full, m_occ == 8'hFF);
      chk("m_empty", empty, m_occ == 8'h00);
      chk("m_err", err_double_free, m_err);
      chk("m_ready", alloc_ready, (m_occ != 8'hFF) && !flush);
      chk("m_idx", alloc_idx, (m_occ == 8'hFF) ? 0 : highest_free(m_occ));
    end
  end

  task automatic drive(input logic req, input logic [7:0] fm, input logic fl);
    @(negedge clk);
    #1;
    alloc_req = req;
    free_mask = fm;
    flush = fl;
  endtask

  initial begin
    #12 reset = 1'b0;
    @(negedge clk); #2;
    // 1: reset / idle
    chk("t1_occupied", occupied, 8'h00);
    chk("t1_free_count", free_count, 8);
    chk("t1_empty", empty, 1);
    chk("t1_ready", alloc_ready, 1);
    chk("t1_idx", alloc_idx, 7);
    // 2: nine requests from empty
    for (int k = 0; k < 9; k++) begin
      drive(1, 8'h00, 0); #1;
      if (k < 8) chk("t2_grant", alloc_idx, 7 - k);
      else chk("t2_ready9", alloc_ready, 0);
    end
    drive(0, 8'h00, 0); #1;
    chk("t2_occupied", occupied, 8'hFF);
    chk("t2_full", full, 1);
    chk("t2_free_count", free_count, 0);
    chk("t2_ready", alloc_ready, 0);
    // 3: free two from full
    drive(0, 8'h24, 0);
    drive(0, 8'h00, 0); #1;
    chk("t3_occupied", occupied, 8'hDB);
    chk("t3_free_count", free_count, 2);
    chk("t3_idx", alloc_idx, 5);
    // 4: build 0F, then alloc and free together
    drive(1, 8'h00, 0);
    drive(1, 8'h00, 0);
    drive(0, 8'hF0, 0);
    drive(1, 8'h01, 0); #1;
    chk("t4_pre_occupied", occupied, 8'h0F);
    chk("t4_idx", alloc_idx, 7);
    drive(0, 8'h00, 0); #1;
    chk("t4_occupied", occupied, 8'h8E);
    chk("t4_free_count", free_count, 4);
    // 5: double free from 01
    for (int k = 0; k < 4; k++) drive(1, 8'h00, 0);
    drive(0, 8'hFE, 0);
    drive(0, 8'h03, 0); #1;
    chk("t5_pre_occupied", occupied, 8'h01);
    drive(0, 8'h00, 0); #1;
    chk("t5_occupied", occupied, 8'h00);
    chk("t5_err", err_double_free, 1);
    drive(0, 8'h00, 0); #1;
    chk("t5_err_gone", err_double_free, 0);
    // 6a: flush beats alloc and free
    for (int k = 0; k < 4; k++) drive(1, 8'h00, 0);
    drive(1, 8'h10, 1); #1;
    chk("t6a_pre_occupied", occupied, 8'hF0);
    chk("t6a_ready", alloc_ready, 0);
    drive(0, 8'h00, 0); #1;
    chk("t6a_occupied", occupied, 8'h00);
    chk("t6a_err", err_double_free, 0);
    // Pseudo-random traffic against the model
    for (int k = 0; k < 200; k++) begin
      logic [7:0] fm;
      fm = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      drive(1'($urandom_range(0, 3) != 0), fm, $urandom_range(0, 24) == 0);
    end
    // 6b: async reset between edges
    drive(1, 8'h00, 0);
    drive(1, 8'h00, 0);
    drive(0, 8'h00, 0); #1;
    chk("t6b_pre_empty", empty, 0);
    reset = 1'b1; #1;
    chk("t6b_occupied", occupied, 8'h00);
    chk("t6b_free_count", free_count, 8);
    chk("t6b_empty", empty, 1);
    chk("t6b_full", full, 0);
    chk("t6b_err", err_double_free, 0);
    #1 reset = 1'b0;
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 0);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
